// File: rtl/tx_pkt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkt_seq
//  Description : Frame sequencer for the 1 Mb/s TX path. Feeds preamble,
//                access address, length header and FIFO payload bytes to
//                the byte serializer and reports done/underflow/abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pkt_seq #(
    parameter logic [7:0] PREAMBLE = 8'hAA,
    parameter int         AA_BYTES = 4,
    parameter int         LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_go,
    input  logic             tx_abort,
    input  logic [31:0]      cfg_aa,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_rd,
    input  logic             ser_en,
    input  logic             ser_ready,
    input  logic             ser_bit_valid,
    output logic             ser_start,
    output logic [7:0]       ser_data,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [1:0]       tx_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PRE   = 3'd1;
    localparam logic [2:0] c_AA    = 3'd2;
    localparam logic [2:0] c_HDR   = 3'd3;
    localparam logic [2:0] c_PLD   = 3'd4;
    localparam logic [2:0] c_DRAIN = 3'd5;

    localparam logic [1:0] c_AA_LAST   = 2'(AA_BYTES - 1);
    localparam logic [1:0] c_ERR_UFLOW = 2'd1;
    localparam logic [1:0] c_ERR_ABORT = 2'd2;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [31:0]      r_aa;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rem;
    logic [1:0]       r_idx;
    logic [1:0]       r_err;
    logic [7:0]       w_hdr;
    logic             w_acc;
    logic             w_underflow;
    logic             w_abort;

    generate
        if (LEN_W >= 8) begin : g_hdr_trunc
            assign w_hdr = r_len[7:0];
        end else begin : g_hdr_ext
            assign w_hdr = {{(8-LEN_W){1'b0}}, r_len};
        end
    endgenerate

    // In payload, start follows FIFO occupancy so an empty FIFO never offers a byte
    assign ser_start = (r_state == c_PRE) || (r_state == c_AA) || (r_state == c_HDR) ||
                       ((r_state == c_PLD) && pl_valid);
    assign w_acc       = ser_start & ser_ready & ser_en;
    assign w_underflow = (r_state == c_PLD) & ser_ready & ser_en & ser_bit_valid & ~pl_valid;
    assign w_abort     = tx_abort & ((r_state == c_PRE) || (r_state == c_AA) ||
                                     (r_state == c_HDR) || (r_state == c_PLD));
    assign tx_busy     = (r_state != c_IDLE);
    assign tx_err      = r_err;

    always_comb begin
        ser_data = 8'h00;
        case (r_state)
            c_PRE:   ser_data = PREAMBLE;
            c_AA:    ser_data = r_aa[{r_idx, 3'b000} +: 8];
            c_HDR:   ser_data = w_hdr;
            c_PLD:   ser_data = pl_data;
            default: ser_data = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        pl_rd       = 1'b0;
        tx_done     = 1'b0;
        case (r_state)
            c_IDLE:  if (tx_go) w_state_nxt = c_PRE;
            c_PRE:   if (w_acc) w_state_nxt = c_AA;
            c_AA:    if (w_acc && (r_idx == c_AA_LAST)) w_state_nxt = c_HDR;
            c_HDR:   if (w_acc) w_state_nxt = (r_len == '0) ? c_DRAIN : c_PLD;
            c_PLD: begin
                if (w_acc) begin
                    pl_rd = 1'b1;
                    if (r_rem == LEN_W'(1)) w_state_nxt = c_DRAIN;
                end else if (w_underflow) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (!ser_bit_valid) begin
                    tx_done     = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        // An accepted byte on the abort cycle is still consumed above
        if (w_abort) w_state_nxt = c_DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_aa    <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (tx_go) begin
                        r_aa  <= cfg_aa;
                        r_len <= cfg_len;
                        r_err <= '0;
                        r_idx <= '0;
                    end
                end
                c_AA:  if (w_acc) r_idx <= r_idx + 2'd1;
                c_HDR: if (w_acc) r_rem <= r_len;
                c_PLD: begin
                    if (w_acc) r_rem <= r_rem - LEN_W'(1);
                    else if (w_underflow) r_err <= c_ERR_UFLOW;
                end
                default: ;
            endcase
            if (w_abort) r_err <= c_ERR_ABORT;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_pkt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_pkt_seq
//  Description : Directed bench for tx_pkt_seq with a bit-counting serializer
//                model and a small payload FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_pkt_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_go, tx_abort;
    logic [31:0] cfg_aa;
    logic [7:0]  cfg_len;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_rd;
    logic        ser_en, ser_ready, ser_bit_valid, ser_start;
    logic [7:0]  ser_data;
    logic        tx_busy, tx_done;
    logic [1:0]  tx_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tx_pkt_seq dut (
        .clk(clk), .rst_n(rst_n), .tx_go(tx_go), .tx_abort(tx_abort),
        .cfg_aa(cfg_aa), .cfg_len(cfg_len), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_rd(pl_rd), .ser_en(ser_en), .ser_ready(ser_ready),
        .ser_bit_valid(ser_bit_valid), .ser_start(ser_start), .ser_data(ser_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    // Serializer clock enable: every cycle, or every other cycle
    logic en_full = 1'b1;
    logic en_phase = 1'b0;
    always @(posedge clk) en_phase <= ~en_phase;
    assign ser_en = en_full | en_phase;

    // Serializer model: one bit per enabled cycle, ready during the last bit
    logic       m_busy;
    logic [2:0] m_cnt;
    assign ser_bit_valid = m_busy;
    assign ser_ready     = ~m_busy | (m_cnt == 3'd7);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 3'd0;
        end else if (ser_en) begin
            if (ser_start & ser_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= 3'd0;
            end else if (m_busy) begin
                if (m_cnt == 3'd7) m_busy <= 1'b0;
                else m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    // First-word-fall-through payload FIFO
    logic [7:0] fifo_mem [0:7];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign pl_valid = (wr_ptr != rd_ptr);
    assign pl_data  = fifo_mem[rd_ptr[2:0]];
    always @(posedge clk) if (pl_rd) rd_ptr <= rd_ptr + 4'd1;

    // Monitor
    logic       mon_clr = 1'b0;
    logic [7:0] cap [0:15];
    int         ncap, rd_cnt, done_cnt, gaps, bad_rd;
    logic [1:0] err_at_done;
    logic       prev_bv = 1'b0;
    always @(posedge clk) begin
        prev_bv <= ser_bit_valid;
        if (mon_clr) begin
            ncap <= 0; rd_cnt <= 0; done_cnt <= 0; gaps <= 0; bad_rd <= 0;
            err_at_done <= 2'd3;
        end else begin
            if (ser_start & ser_ready & ser_en) begin
                if (ncap < 16) cap[ncap] <= ser_data;
                ncap <= ncap + 1;
            end
            if (pl_rd) rd_cnt <= rd_cnt + 1;
            if (pl_rd & ~ser_en) bad_rd <= bad_rd + 1;
            if (tx_done) begin
                done_cnt    <= done_cnt + 1;
                err_at_done <= tx_err;
            end
            if (prev_bv & ~ser_bit_valid) gaps <= gaps + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[2:0]] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic start_frame(input logic [31:0] aa, input logic [7:0] len);
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
        cfg_aa = aa; cfg_len = len; tx_go = 1'b1;
        @(negedge clk); tx_go = 1'b0;
        check("busy_after_go", tx_busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic post_check(input string tag, input logic [63:0] exp, input int n,
                              input int exp_rd, input logic [1:0] exp_err);
        check({tag, "_nbytes"}, ncap, n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), cap[i], exp[8*(n-1-i) +: 8]);
        check({tag, "_pl_rd"}, rd_cnt, exp_rd);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err_at_done"}, err_at_done, exp_err);
        check({tag, "_err_held"}, tx_err, exp_err);
        check({tag, "_gaps"}, gaps, 1);
        check({tag, "_rd_no_en"}, bad_rd, 0);
        check({tag, "_busy_end"}, tx_busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; tx_go = 1'b0; tx_abort = 1'b0; cfg_aa = '0; cfg_len = '0;
        repeat (2) @(negedge clk);
        check("rst_ser_start", ser_start, 0);
        check("rst_ser_data", ser_data, 0);
        check("rst_pl_rd", pl_rd, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame
        push(8'h11); push(8'h22);
        start_frame(32'h8E89BED6, 8'd2);
        wait_done("nom");
        post_check("nom", 64'hAAD6BE898E021122, 8, 2, 2'd0);

        // Zero-length payload
        start_frame(32'h01020304, 8'd0);
        wait_done("len0");
        post_check("len0", 64'h0000AA0403020100, 6, 0, 2'd0);

        // Underflow: only one of three payload bytes available
        push(8'h55);
        start_frame(32'hA1B2C3D4, 8'd3);
        wait_done("uflow");
        post_check("uflow", 64'h00AAD4C3B2A10355, 7, 1, 2'd1);

        // Abort while AA byte 2 is presented; tx_go while busy must be ignored
        begin
            int n = 0;
            start_frame(32'h8E89BED6, 8'd2);
            while (ncap < 3 && n < 500) begin @(negedge clk); n++; end
            check("abort_reach_aa2", ncap, 3);
            check("abort_aa2_data", ser_data, 8'h89);
            tx_abort = 1'b1; tx_go = 1'b1;
            @(negedge clk);
            tx_abort = 1'b0;
            check("abort_start_low", ser_start, 0);
            check("abort_busy", tx_busy, 1);
            repeat (3) @(negedge clk);
            tx_go = 1'b0;
            wait_done("abort");
            post_check("abort", 64'h0000000000AAD6BE, 3, 0, 2'd2);
        end

        // Half-rate serializer enable
        en_full = 1'b0;
        push(8'h11); push(8'h22);
        start_frame(32'h8E89BED6, 8'd2);
        wait_done("half");
        post_check("half", 64'hAAD6BE898E021122, 8, 2, 2'd0);
        en_full = 1'b1;

        // Reset in the middle of the payload
        begin
            int n = 0;
            push(8'h01); push(8'h02); push(8'h03);
            start_frame(32'h01020304, 8'd3);
            while (rd_cnt < 1 && n < 500) begin @(negedge clk); n++; end
            check("rst_mid_reach_pld", rd_cnt, 1);
            rst_n = 1'b0;
            #1;
            check("rst_mid_start", ser_start, 0);
            check("rst_mid_data", ser_data, 0);
            check("rst_mid_pl_rd", pl_rd, 0);
            check("rst_mid_busy", tx_busy, 0);
            check("rst_mid_done", tx_done, 0);
            check("rst_mid_err", tx_err, 0);
            @(negedge clk);
            rst_n = 1'b1;
            wr_ptr = rd_ptr;
            repeat (2) @(negedge clk);
            check("rst_mid_no_done", done_cnt, 0);
            push(8'h5A);
            start_frame(32'h01020304, 8'd1);
            wait_done("after_rst");
            post_check("after_rst", 64'h00AA04030201015A, 7, 1, 2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
